trinity_bus_seq: RTL and testbench

Command sequencer sitting directly upstream of the Trinity accumulator core. It accepts accumulate commands (mode, operand, repeat count) over a valid/ready handshake and buffers them in a small FIFO. It replays each command onto the core's 8-bit control bus and 8-bit operand lines, one issue per cycle, with no bubbles between back-to-back commands. Registered outputs connect straight to the core's `bus_in`/`data_in`.

---
 rtl/trinity_pkg.sv | 36 +++
 rtl/trinity_cmd_fifo.sv | 51 +++++
 rtl/trinity_bus_seq.sv | 99 +++++++++
 tb/tb_trinity_bus_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trinity_pkg.sv
// Shared definitions for the Trinity command sequencer and accumulator core:
// control-bus bit positions, mode codes, sequencer state encoding and command layout.
package trinity_pkg;

  localparam int BUS_VALID   = 7;
  localparam int BUS_EXEC    = 2;
  localparam int BUS_MODE_HI = 1;
  localparam int BUS_MODE_LO = 0;

  localparam logic [1:0] MODE_ADD  = 2'd0;
  localparam logic [1:0] MODE_ADD3 = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_NOP  = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [3:0] rpt;
    logic [1:0] mode;
    logic [7:0] data;
  } cmd_t;

  // NOP drives a valid slot without exec so the core sees a timed gap.
  function automatic logic [7:0] issue_bus(input logic [1:0] mode);
    logic [7:0] b;
    b = '0;
    b[BUS_VALID] = 1'b1;
    b[BUS_EXEC] = (mode != MODE_NOP);
    b[BUS_MODE_HI:BUS_MODE_LO] = mode;
    return b;
  endfunction

endpackage

// File: rtl/trinity_cmd_fifo.sv
// Command FIFO, DEPTH x cmd_t; head is visible combinationally, level is registered.
// Caller never pushes when full or pops when empty; clr empties it on the next edge.
module trinity_cmd_fifo
  import trinity_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  cmd_t                         wdata,
  input  logic                         pop,
  output cmd_t                         rdata,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trinity_bus_seq.sv
// Buffers accumulate commands and replays each rpt+1 times onto the core bus, one issue
// per cycle with no bubbles; first issue appears one edge after the accepting edge.
module trinity_bus_seq
  import trinity_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_mode,
  input  logic [7:0]                   cmd_data,
  input  logic [3:0]                   cmd_rpt,
  input  logic                         hold,
  input  logic                         flush,
  output logic [7:0]                   bus_out,
  output logic [7:0]                   core_data,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [CNT_W-1:0]             issue_cnt
);

  localparam int LVL_W = $clog2(DEPTH+1);

  seq_state_t state;
  logic [3:0] rem;
  logic [1:0] cur_mode;
  cmd_t       wr_cmd;
  cmd_t       head;
  logic       push;
  logic       pop;
  logic       fire;
  logic [1:0] fire_mode;
  logic       fifo_empty;

  assign fifo_empty = (fifo_level == '0);
  assign cmd_ready  = (fifo_level < LVL_W'(DEPTH)) && !flush;
  assign push       = cmd_valid && cmd_ready;
  assign busy       = (state == ST_ISSUE) || !fifo_empty;
  assign wr_cmd     = '{rpt: cmd_rpt, mode: cmd_mode, data: cmd_data};

  trinity_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (flush),
    .push      (push),
    .wdata     (wr_cmd),
    .pop       (pop),
    .rdata     (head),
    .level     (fifo_level)
  );

  // Finishing a command and popping the next share one edge, so back-to-back has no gap.
  always_comb begin
    pop       = 1'b0;
    fire      = 1'b0;
    fire_mode = cur_mode;
    if (!flush && !hold) begin
      if (state == ST_ISSUE && rem != '0) begin
        fire = 1'b1;
      end else if (!fifo_empty) begin
        pop       = 1'b1;
        fire      = 1'b1;
        fire_mode = head.mode;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      rem       <= '0;
      cur_mode  <= MODE_ADD;
      bus_out   <= '0;
      core_data <= '0;
      issue_cnt <= '0;
    end else if (flush) begin
      state   <= ST_IDLE;
      rem     <= '0;
      bus_out <= '0;
    end else begin
      bus_out <= fire ? issue_bus(fire_mode) : '0;
      if (fire && fire_mode != MODE_NOP) issue_cnt <= issue_cnt + CNT_W'(1);
      if (pop) begin
        state     <= ST_ISSUE;
        rem       <= head.rpt;
        cur_mode  <= head.mode;
        core_data <= head.data;
      end else if (fire) begin
        rem <= rem - 4'd1;
      end else if (!hold) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_trinity_bus_seq.sv
// Directed + randomized bench for trinity_bus_seq against a queue-based command model.
module tb_trinity_bus_seq;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_mode = '0;
  logic [7:0]  cmd_data = '0;
  logic [3:0]  cmd_rpt = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  bus_out;
  logic [7:0]  core_data;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] issue_cnt;

  always #5 sys_clk = ~sys_clk;

  trinity_bus_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_data   (cmd_data),
    .cmd_rpt    (cmd_rpt),
    .hold       (hold),
    .flush      (flush),
    .bus_out    (bus_out),
    .core_data  (core_data),
    .busy       (busy),
    .fifo_level (fifo_level),
    .issue_cnt  (issue_cnt)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int rpt;
    int mode;
    int data;
  } cmd_rec_t;

  cmd_rec_t q[$];
  cmd_rec_t cur;
  int       left = 0;
  bit       active = 0;
  int       exp_bus = 0;
  int       exp_data = 0;
  int       exp_cnt = 0;
  int       acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready();
    return (q.size() < DEPTH) && !flush;
  endfunction

  task automatic emit();
    exp_bus  = (cur.mode == 3) ? 'h83 : ('h84 | cur.mode);
    exp_data = cur.data;
    if (cur.mode != 3) exp_cnt = (exp_cnt + 1) % 65536;
  endtask

  task automatic model_reset();
    q.delete();
    active = 0;
    left = 0;
    exp_bus = 0;
    exp_data = 0;
    exp_cnt = 0;
  endtask

  // One clock edge of the sequencer, expressed as command-level rules.
  task automatic model_edge();
    bit rdy;
    cmd_rec_t n;
    rdy = model_ready();
    if (flush) begin
      q.delete();
      active = 0;
      left = 0;
      exp_bus = 0;
    end else begin
      exp_bus = 0;
      if (!hold) begin
        if (active && left > 0) begin
          left--;
          emit();
        end else if (q.size() > 0) begin
          cur = q.pop_front();
          left = cur.rpt;
          active = 1;
          emit();
        end else begin
          active = 0;
        end
      end
    end
    if (cmd_valid && rdy) begin
      n.rpt = int'(cmd_rpt);
      n.mode = int'(cmd_mode);
      n.data = int'(cmd_data);
      q.push_back(n);
    end
  endtask

  task automatic step();
    #1;
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, model_ready()});
    model_edge();
    @(posedge sys_clk);
    #1;
    chk("bus_out", {24'd0, bus_out}, exp_bus);
    chk("core_data", {24'd0, core_data}, exp_data);
    chk("issue_cnt", {16'd0, issue_cnt}, exp_cnt);
    chk("fifo_level", {29'd0, fifo_level}, q.size());
    chk("busy", {31'd0, busy}, {31'd0, (active || q.size() > 0)});
    if (bus_out[7] && bus_out[2]) begin
      case (bus_out[1:0])
        2'd0: acc = acc + int'(core_data);
        2'd1: acc = acc + 3 * int'(core_data);
        2'd2: acc = acc ^ int'(core_data);
        default: ;
      endcase
    end
  endtask

  task automatic push_cmd(input logic [1:0] m, input logic [7:0] d, input logic [3:0] r);
    cmd_valid = 1'b1;
    cmd_mode = m;
    cmd_data = d;
    cmd_rpt = r;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int total;
    int gaps;
    logic [3:0] r;

    #2;
    chk("rst_bus", {24'd0, bus_out}, 0);
    chk("rst_data", {24'd0, core_data}, 0);
    chk("rst_cnt", {16'd0, issue_cnt}, 0);
    chk("rst_level", {29'd0, fifo_level}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_reset();

    // Single ADD, no repeat.
    push_cmd(2'd0, 8'h05, 4'd0);
    repeat (4) step();
    chk("t1_cnt", {16'd0, issue_cnt}, 1);
    chk("t1_busy", {31'd0, busy}, 0);

    // ADD3 x3 drives the core accumulator to 27.
    acc = 0;
    push_cmd(2'd1, 8'h03, 4'd2);
    repeat (5) step();
    chk("t2_acc", acc, 27);
    chk("t2_cnt", {16'd0, issue_cnt}, 4);

    // Fill under hold, then release and expect a gap-free burst.
    hold = 1'b1;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      r = 4'($urandom_range(0, 2));
      total += int'(r) + 1;
      push_cmd(2'($urandom_range(0, 3)), 8'($urandom), r);
    end
    #1;
    chk("t3_ready_full", {31'd0, cmd_ready}, 0);
    chk("t3_level", {29'd0, fifo_level}, 4);
    chk("t3_bus_held", {24'd0, bus_out}, 0);
    hold = 1'b0;
    gaps = 0;
    for (int i = 0; i < total; i++) begin
      step();
      if (bus_out == 8'h00) gaps++;
    end
    chk("t3_gaps", gaps, 0);
    repeat (2) step();
    chk("t3_idle_bus", {24'd0, bus_out}, 0);

    // NOP x4 as a timed gap, then one XOR.
    push_cmd(2'd3, 8'h11, 4'd3);
    push_cmd(2'd2, 8'hFF, 4'd0);
    repeat (6) step();

    // Flush during the second issue of a long command with two queued behind it.
    push_cmd(2'd0, 8'h21, 4'd5);
    push_cmd(2'd1, 8'h22, 4'd1);
    push_cmd(2'd2, 8'h23, 4'd0);
    chk("t5_second_issue", {24'd0, bus_out}, 'h84);
    flush = 1'b1;
    cmd_valid = 1'b1;
    step();
    flush = 1'b0;
    cmd_valid = 1'b0;
    chk("t5_bus", {24'd0, bus_out}, 0);
    chk("t5_level", {29'd0, fifo_level}, 0);
    repeat (3) step();

    // Asynchronous reset in the middle of a repeat.
    push_cmd(2'd0, 8'h44, 4'd7);
    repeat (3) step();
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_bus", {24'd0, bus_out}, 0);
    chk("t6_data", {24'd0, core_data}, 0);
    chk("t6_cnt", {16'd0, issue_cnt}, 0);
    chk("t6_level", {29'd0, fifo_level}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    model_reset();
    @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b1;
    push_cmd(2'd2, 8'h5A, 4'd1);
    repeat (4) step();
    chk("t6_after_cnt", {16'd0, issue_cnt}, 2);

    // Randomized traffic with occasional hold and flush.
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom % 3) != 0;
      cmd_mode = 2'($urandom);
      cmd_data = 8'($urandom);
      cmd_rpt = 4'($urandom_range(0, 3));
      hold = ($urandom % 8) == 0;
      flush = ($urandom % 40) == 0;
      step();
    end
    cmd_valid = 1'b0;
    hold = 1'b0;
    flush = 1'b0;
    repeat (30) step();
    chk("drain_busy", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
